// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR    = 32'h0000_0013;

  // One buffered fetch result: instruction word plus the PC it came from.
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Word-align an address by clearing the two byte-offset bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute
// redirect and the decode handoff. The master side is the fetch unit.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [ILEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO with flush. DEPTH must be a power of two so the
// pointers wrap naturally. Flush has priority over push and pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep count.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];
  assign full = (count == DEPTH[AW:0]);

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues word fetches under a
// credit limit, buffers in-order responses for decode and kills wrong-path
// work on an execute redirect.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched/perf_stall/perf_flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_VECTOR,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDIT = FIFO_DEPTH[CW:0];

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   tag_count;
  logic            buf_full;
  logic            tag_full;
  fetch_entry_t    buf_head;
  fetch_entry_t    buf_push_data;
  logic [XLEN-1:0] tag_head;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_keep;
  logic            id_fire;

  // Outstanding requests plus buffered words may never exceed the buffer
  // size, so every response is guaranteed a slot.
  assign credit_ok          = ({1'b0, outstanding} + {1'b0, buf_count}) < CREDIT;
  assign bus.imem_req_valid = !reset && !bus.redirect_valid && credit_ok;
  assign bus.imem_req_addr  = pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // A response arriving with a redirect belongs to the old path and is dropped.
  assign rsp_keep      = bus.imem_rsp_valid && (discard == '0) && !bus.redirect_valid;
  assign id_fire       = bus.id_valid && bus.id_ready && !bus.redirect_valid;
  assign buf_push_data = '{instr: bus.imem_rsp_data, pc: tag_head};

  assign bus.id_valid = !reset && (buf_count != '0);
  assign bus.id_instr = bus.id_valid ? buf_head.instr : '0;
  assign bus.id_pc    = bus.id_valid ? buf_head.pc    : '0;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_instr_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect_valid),
    .push      (rsp_keep),
    .push_data (buf_push_data),
    .pop       (id_fire),
    .head      (buf_head),
    .count     (buf_count),
    .full      (buf_full)
  );

  // Tags of in-flight requests; never flushed by a redirect because the
  // dropped responses still have to consume their tags.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_pc_tags (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc),
    .pop       (bus.imem_rsp_valid),
    .head      (tag_head),
    .count     (tag_count),
    .full      (tag_full)
  );

  // PC, in-flight count and wrong-path discard count; redirect wins over issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.redirect_valid) begin
        pc      <= align_pc(bus.redirect_pc);
        discard <= outstanding - CW'(bus.imem_rsp_valid);
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (bus.imem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end

  a_rsp_has_request: assert property (@(posedge clk) disable iff (reset)
    bus.imem_rsp_valid |-> (outstanding != '0));
  a_tags_track_outstanding: assert property (@(posedge clk) disable iff (reset)
    (tag_count == outstanding) && !(tag_full && req_fire && !bus.imem_rsp_valid));
  a_buf_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(buf_full && rsp_keep && !id_fire));

`ifdef FETCH_PERF_CNT_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else begin
      if (id_fire)            perf_fetched <= perf_fetched + 32'd1;
      if (!bus.id_valid)      perf_stall   <= perf_stall + 32'd1;
      if (bus.redirect_valid) perf_flush   <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized memory/decode/redirect
// stimulus against an architectural model of the expected PC streams.
module tb_fetch_unit;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_unit_if bus();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

   fetch_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall),
      .perf_flush   (perf_flush)
`endif
   );

   int errors = 0;
   int checks = 0;

   int   p_ready, p_idready, p_rsp, p_redir, lat_min, lat_max;
   bit   toggle_ready = 0;
   logic tog = 1'b0;
   bit   force_redir = 0;
   logic [31:0] force_tgt = '0;
   bit   redir_on_rsp_head = 0;
   bit   redir_hit = 0;
   logic [31:0] last_tgt = '0;

   int          cyc = 0;
   logic [31:0] exp_req, exp_pc;
   int          acc_since, dec_since, tb_out, decoded_total, last_due;
   logic [31:0] mq_addr[$];
   int          mq_due[$];
   bit          prev_stall;
   logic [31:0] prev_addr;
   logic [31:0] m_fetched, m_stall, m_flush;
   logic [31:0] pm_fetched, pm_stall, pm_flush;

   logic        s_req_valid, s_rsp_valid, s_id_valid;
   logic [31:0] s_addr, s_id_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] s_pf, s_ps, s_pl;
`endif

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE13;
   endfunction

   function automatic logic [31:0] aligned(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   task automatic set_mode(input int rdy, input int idr, input int rsp, input int rdr,
                           input int lmin, input int lmax);
      p_ready = rdy; p_idready = idr; p_rsp = rsp; p_redir = rdr;
      lat_min = lmin; lat_max = lmax;
   endtask

   task automatic model_clear();
      mq_addr.delete(); mq_due.delete();
      tb_out = 0; acc_since = 0; dec_since = 0; last_due = 0;
      exp_req = 32'h0; exp_pc = 32'h0; prev_stall = 0; prev_addr = '0;
      m_fetched = '0; m_stall = '0; m_flush = '0;
   endtask

   task automatic step();
      logic rdy, idr, rsp, redir;
      logic [31:0] tgt;
      int due;
      if (toggle_ready) begin tog = ~tog; rdy = tog; end
      else rdy = ($urandom_range(0, 99) < p_ready);
      idr = ($urandom_range(0, 99) < p_idready);
      rsp = (mq_addr.size() > 0) && ($urandom_range(0, 99) < p_rsp);
      if (rsp && (mq_due[0] > cyc)) rsp = 1'b0;
      bus.imem_req_ready = rdy;
      bus.id_ready       = idr;
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rsp ? mem_word(mq_addr[0]) : $urandom();
      redir = force_redir || ($urandom_range(0, 99) < p_redir);
      if (redir_on_rsp_head) redir = rsp && idr && bus.id_valid;
      tgt = force_redir ? force_tgt : $urandom();
      bus.redirect_valid = redir;
      bus.redirect_pc    = tgt;
      #1;
      s_req_valid = bus.imem_req_valid;
      s_addr      = bus.imem_req_addr;
      s_rsp_valid = rsp;
      s_id_valid  = bus.id_valid;
      s_id_pc     = bus.id_pc;
`ifdef FETCH_PERF_CNT_EN
      s_pf = perf_fetched; s_ps = perf_stall; s_pl = perf_flush;
`endif
      pm_fetched = m_fetched; pm_stall = m_stall; pm_flush = m_flush;

      if (redir) begin
         checks++;
         if (s_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL req_masked_on_redirect: got valid=%b required 0", s_req_valid);
         end
      end else if (prev_stall) begin
         checks++;
         if (s_req_valid !== 1'b1 || s_addr !== prev_addr) begin
            errors++;
            $display("FAIL req_hold: got valid=%b addr=%h required valid=1 addr=%h",
                     s_req_valid, s_addr, prev_addr);
         end
      end
      if (s_req_valid === 1'b1) begin
         checks++;
         if (s_addr !== exp_req) begin
            errors++;
            $display("FAIL req_addr: got %h required %h", s_addr, exp_req);
         end
      end
      if (s_id_valid === 1'b1) begin
         checks++;
         if (s_id_pc !== exp_pc || bus.id_instr !== mem_word(exp_pc)) begin
            errors++;
            $display("FAIL id_pair: got pc=%h instr=%h required pc=%h instr=%h",
                     s_id_pc, bus.id_instr, exp_pc, mem_word(exp_pc));
         end
      end
      checks++;
      if ((acc_since - dec_since) > DEPTH || tb_out > DEPTH) begin
         errors++;
         $display("FAIL credit: got live=%0d inflight=%0d required <=%0d",
                  acc_since - dec_since, tb_out, DEPTH);
      end

      if (s_req_valid === 1'b1 && rdy) begin
         due = cyc + $urandom_range(lat_min, lat_max);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mq_addr.push_back(s_addr);
         mq_due.push_back(due);
         exp_req += 32'd4;
         acc_since++;
         tb_out++;
      end
      if (rsp) begin
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
         tb_out--;
      end
      if (redir) begin
         exp_req = aligned(tgt);
         exp_pc  = aligned(tgt);
         acc_since = 0; dec_since = 0;
         m_flush += 32'd1;
         last_tgt = tgt;
      end else if (s_id_valid === 1'b1 && idr) begin
         exp_pc += 32'd4;
         dec_since++;
         decoded_total++;
         m_fetched += 32'd1;
      end
      if (s_id_valid !== 1'b1) m_stall += 32'd1;
      prev_stall = (s_req_valid === 1'b1) && !rdy && !redir;
      prev_addr  = s_addr;
      if (redir && redir_on_rsp_head) begin redir_on_rsp_head = 0; redir_hit = 1; end
      force_redir = 0;
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      bus.imem_rsp_valid = 1'b0; bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b1; bus.id_ready = 1'b1;
      mq_addr.delete(); mq_due.delete();
      for (int i = 0; i < n; i++) begin
         #1;
         checks++;
         if (bus.imem_req_valid !== 1'b0 || bus.id_valid !== 1'b0 ||
             bus.id_instr !== 32'h0 || bus.id_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b idv=%b instr=%h pc=%h required 0,0,0,0",
                     bus.imem_req_valid, bus.id_valid, bus.id_instr, bus.id_pc);
         end
         @(negedge clk);
      end
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      set_mode(100, 100, 100, 0, 1, 1);
      do_reset(3);
      step();
      checks++;
      if (s_req_valid !== 1'b1 || s_addr !== 32'h0 || s_id_valid !== 1'b0) begin
         errors++;
         $display("FAIL first_request: got valid=%b addr=%h idv=%b required 1 00000000 0",
                  s_req_valid, s_addr, s_id_valid);
      end
   endtask

   task automatic test_stream();
      int start = decoded_total;
      set_mode(100, 100, 100, 0, 1, 1);
      for (int i = 0; i < 60; i++) step();
      checks++;
      if (decoded_total - start < 20) begin
         errors++;
         $display("FAIL stream_progress: got %0d decoded required >=20", decoded_total - start);
      end
   endtask

   task automatic test_latency();
      int n = 0;
      do_reset(2);
      set_mode(100, 0, 100, 0, 1, 1);
      do begin step(); n++; end while (!s_rsp_valid && n < 20);
      checks++;
      if (!s_rsp_valid || s_id_valid !== 1'b0) begin
         errors++;
         $display("FAIL rsp_no_bypass: got rsp=%b idv=%b required 1 0", s_rsp_valid, s_id_valid);
      end
      step();
      checks++;
      if (s_id_valid !== 1'b1 || s_id_pc !== 32'h0) begin
         errors++;
         $display("FAIL rsp_latency: got idv=%b pc=%h required 1 00000000", s_id_valid, s_id_pc);
      end
   endtask

   task automatic test_backpressure();
      int start;
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (s_req_valid !== 1'b0 || acc_since != DEPTH) begin
         errors++;
         $display("FAIL backpressure_credit: got req=%b accepted=%0d required 0 %0d",
                  s_req_valid, acc_since, DEPTH);
      end
      start = decoded_total;
      p_idready = 100;
      for (int i = 0; i < 20; i++) step();
      checks++;
      if (decoded_total - start < 4) begin
         errors++;
         $display("FAIL backpressure_release: got %0d decoded required >=4", decoded_total - start);
      end
   endtask

   task automatic test_req_stall();
      int start;
      do_reset(2);
      set_mode(100, 100, 100, 0, 1, 2);
      toggle_ready = 1; tog = 1'b0;
      start = decoded_total;
      for (int i = 0; i < 40; i++) step();
      toggle_ready = 0;
      checks++;
      if (decoded_total - start < 8) begin
         errors++;
         $display("FAIL req_stall_progress: got %0d decoded required >=8", decoded_total - start);
      end
   endtask

   task automatic test_redirect();
      int n = 0;
      do_reset(2);
      set_mode(100, 0, 100, 0, 3, 3);
      while (tb_out != 2 && n < 20) begin step(); n++; end
      checks++;
      if (tb_out != 2) begin
         errors++;
         $display("FAIL redirect_setup: got inflight=%0d required 2", tb_out);
      end
      force_redir = 1; force_tgt = 32'h100;
      step();
      p_idready = 100;
      n = 0;
      do begin step(); n++; end while (s_id_valid !== 1'b1 && n < 30);
      checks++;
      if (s_id_valid !== 1'b1 || s_id_pc !== 32'h100) begin
         errors++;
         $display("FAIL redirect_first_pc: got idv=%b pc=%h required 1 00000100", s_id_valid, s_id_pc);
      end
   endtask

   task automatic test_redirect_rsp_head();
      int n = 0;
      do_reset(2);
      set_mode(100, 100, 100, 0, 1, 1);
      redir_hit = 0; redir_on_rsp_head = 1;
      while (!redir_hit && n < 100) begin step(); n++; end
      redir_on_rsp_head = 0;
      checks++;
      if (!redir_hit) begin
         errors++;
         $display("FAIL redirect_rsp_head_timeout: got no coincidence in %0d cycles", n);
      end
      step();
      checks++;
      if (s_id_valid !== 1'b0) begin
         errors++;
         $display("FAIL redirect_head_killed: got idv=%b required 0", s_id_valid);
      end
      n = 0;
      while (s_id_valid !== 1'b1 && n < 20) begin step(); n++; end
      checks++;
      if (s_id_valid !== 1'b1 || s_id_pc !== aligned(last_tgt)) begin
         errors++;
         $display("FAIL redirect_rsp_first_pc: got idv=%b pc=%h required 1 %h",
                  s_id_valid, s_id_pc, aligned(last_tgt));
      end
   endtask

   task automatic test_misaligned_and_wrap();
      int  n = 0;
      bit  seen0 = 0;
      set_mode(100, 100, 100, 0, 1, 1);
      force_redir = 1; force_tgt = 32'h203;
      step();
      do begin step(); n++; end while (s_req_valid !== 1'b1 && n < 10);
      checks++;
      if (s_req_valid !== 1'b1 || s_addr !== 32'h200) begin
         errors++;
         $display("FAIL misaligned_target: got valid=%b addr=%h required 1 00000200", s_req_valid, s_addr);
      end
      force_redir = 1; force_tgt = 32'hFFFF_FFF8;
      step();
      for (int i = 0; i < 20; i++) begin
         step();
         if (s_req_valid === 1'b1 && s_addr === 32'h0) seen0 = 1;
      end
      checks++;
      if (!seen0 || exp_pc < 32'h4) begin
         errors++;
         $display("FAIL pc_wrap: got seen0=%b next_pc=%h required 1 and >=00000004", seen0, exp_pc);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      set_mode(100, 50, 100, 0, 2, 4);
      for (int i = 0; i < 15; i++) step();
      do_reset(2);
      set_mode(100, 100, 100, 0, 1, 2);
      do begin step(); n++; end while (s_id_valid !== 1'b1 && n < 20);
      checks++;
      if (s_id_valid !== 1'b1 || s_id_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_restart: got idv=%b pc=%h required 1 00000000", s_id_valid, s_id_pc);
      end
   endtask

   task automatic test_random();
      int start;
      do_reset(2);
      set_mode(70, 60, 80, 5, 1, 4);
      start = decoded_total;
      for (int i = 0; i < 3000; i++) step();
      set_mode(100, 100, 100, 0, 1, 1);
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (decoded_total - start < 300) begin
         errors++;
         $display("FAIL random_progress: got %0d decoded required >=300", decoded_total - start);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (s_pf !== pm_fetched || s_ps !== pm_stall || s_pl !== pm_flush) begin
         errors++;
         $display("FAIL perf_counters: got %0d/%0d/%0d required %0d/%0d/%0d",
                  s_pf, s_ps, s_pl, pm_fetched, pm_stall, pm_flush);
      end
`endif
   endtask

   initial begin
      reset = 1'b1;
      bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
      bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
      decoded_total = 0;
      model_clear();
      @(negedge clk);
      test_reset();
      test_stream();
      test_latency();
      test_backpressure();
      test_req_stall();
      test_redirect();
      test_redirect_rsp_head();
      test_misaligned_and_wrap();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
